// File: rtl/cla_pkg.sv
// Shared types and helpers for the carry-pipelined CLA adder/subtractor.
// The stage control record travels with each beat. The beat's sum and
// operand slices are WIDTH-dependent, so they live alongside it in the top.
package cla_pkg;

   // Generate/propagate pair of a bit or a group of bits.
   typedef struct packed {
      logic g;
      logic p;
   } gp_t;

   // Per-stage control record: beat present, carry out of the slice just
   // computed, and the add/sub selector for the slices still to come.
   typedef struct packed {
      logic valid;
      logic carry;
      logic sub;
   } stage_ctrl_t;

   // Number of pipeline stages, one per GROUP-bit slice.
   function automatic int calc_stages(input int width, input int group);
      return width / group;
   endfunction

   // Combine a higher GP pair with the lower, adjacent GP pair.
   function automatic gp_t gp_combine(input gp_t hi, input gp_t lo);
      gp_t r;
      r.g = hi.g | (hi.p & lo.g);
      r.p = hi.p & lo.p;
      return r;
   endfunction

endpackage

// File: rtl/cla_gp_slice.sv
// Combinational GROUP-bit carry-lookahead slice: sum, carry out, group G/P
// and the carry into the slice MSB (used for signed-overflow detection).
module cla_gp_slice
   import cla_pkg::*;
#(
   parameter int GROUP = 8
) (
   input  logic [GROUP-1:0] a_i,
   input  logic [GROUP-1:0] b_i,
   input  logic             cin_i,
   output logic [GROUP-1:0] sum_o,
   output logic             cout_o,
   output logic             g_o,
   output logic             p_o,
   output logic             cmsb_o
);

   logic [GROUP-1:0] g_bit;
   logic [GROUP-1:0] p_bit;
   logic [GROUP:0]   carry;
   gp_t              gp_pre;

   assign g_bit = a_i & b_i;
   assign p_bit = a_i ^ b_i;

   // Prefix-combine bit G/P so each carry is a flat lookahead term of cin_i.
   always_comb begin
      gp_pre   = '{g: g_bit[0], p: p_bit[0]};
      carry    = '0;
      carry[0] = cin_i;
      carry[1] = gp_pre.g | (gp_pre.p & cin_i);
      for (int i = 1; i < GROUP; i++) begin
         gp_pre       = gp_combine('{g: g_bit[i], p: p_bit[i]}, gp_pre);
         carry[i + 1] = gp_pre.g | (gp_pre.p & cin_i);
      end
   end

   assign sum_o  = p_bit ^ carry[GROUP-1:0];
   assign cout_o = carry[GROUP];
   assign cmsb_o = carry[GROUP-1];
   assign g_o    = gp_pre.g;
   assign p_o    = gp_pre.p;

endmodule

// File: rtl/cla_pipe_adder.sv
// Carry-pipelined carry-lookahead adder/subtractor with valid/ready
// handshake. Stage k resolves slice k using the carry registered by stage
// k-1; the last stage's registers are the output registers.
// Optional: define CLA_PIPE_FLAGS_EN to add registered out_zero / out_neg.
module cla_pipe_adder
   import cla_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int GROUP = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_sub,
   input  logic             in_cin,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_cout,
   output logic             out_ovf
`ifdef CLA_PIPE_FLAGS_EN
   ,
   output logic             out_zero,
   output logic             out_neg
`endif
);

   localparam int STAGES = calc_stages(WIDTH, GROUP);

   if ((WIDTH % GROUP) != 0) begin : g_bad_width
      $error("cla_pipe_adder: WIDTH must be a multiple of GROUP");
   end

   // Stage registers. Operand vectors carry the not-yet-used upper slices
   // forward; the sum vector accumulates the resolved lower slices.
   stage_ctrl_t      ctrl_q [STAGES];
   logic [WIDTH-1:0] sum_q  [STAGES];
   logic [WIDTH-1:0] a_q    [STAGES];
   logic [WIDTH-1:0] b_q    [STAGES];
   logic [WIDTH-1:0] sum_d  [STAGES];
   logic             ovf_q;

   // Slice inputs/outputs, one set per stage.
   logic [GROUP-1:0]  sl_a   [STAGES];
   logic [GROUP-1:0]  sl_b   [STAGES];
   logic [GROUP-1:0]  sl_sum [STAGES];
   logic [STAGES-1:0] sl_cin;
   logic [STAGES-1:0] sl_cout;
   logic [STAGES-1:0] sl_g;
   logic [STAGES-1:0] sl_p;
   logic [STAGES-1:0] sl_cmsb;

   logic en;

   // Whole pipe advances unless a valid result is being held back.
   assign en       = !out_valid || out_ready;
   assign in_ready = en;

   // Select each stage's operand slice and carry-in; subtraction inverts B.
   always_comb begin
      // NOTE: every comb output gets a default first so no path can infer a latch.
      sl_a      = '{default: '0};
      sl_b      = '{default: '0};
      sl_cin    = '0;
      sl_a[0]   = in_a[GROUP-1:0];
      sl_b[0]   = in_b[GROUP-1:0] ^ {GROUP{in_sub}};
      sl_cin[0] = in_sub | in_cin;
      for (int k = 1; k < STAGES; k++) begin
         sl_a[k]   = a_q[k-1][k*GROUP +: GROUP];
         sl_b[k]   = b_q[k-1][k*GROUP +: GROUP] ^ {GROUP{ctrl_q[k-1].sub}};
         sl_cin[k] = ctrl_q[k-1].carry;
      end
   end

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      cla_gp_slice #(.GROUP(GROUP)) u_slice (
         .a_i    (sl_a[k]),
         .b_i    (sl_b[k]),
         .cin_i  (sl_cin[k]),
         .sum_o  (sl_sum[k]),
         .cout_o (sl_cout[k]),
         .g_o    (sl_g[k]),
         .p_o    (sl_p[k]),
         .cmsb_o (sl_cmsb[k])
      );
   end

   // Merge each freshly computed slice into the partial sum it travels with.
   always_comb begin
      for (int k = 0; k < STAGES; k++) begin
         sum_d[k] = (k == 0) ? '0 : sum_q[(k == 0) ? 0 : k-1];
         sum_d[k][k*GROUP +: GROUP] = sl_sum[k];
      end
   end

`ifdef CLA_PIPE_FLAGS_EN
   logic zero_q;
   logic neg_q;
`endif

   // Shift all stages together on en; bubbles shift like beats and hold likewise.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: datapath registers are reset too so the outputs read 0 after reset.
         for (int k = 0; k < STAGES; k++) begin
            ctrl_q[k] <= '0;
            sum_q[k]  <= '0;
            a_q[k]    <= '0;
            b_q[k]    <= '0;
         end
         ovf_q <= 1'b0;
`ifdef CLA_PIPE_FLAGS_EN
         zero_q <= 1'b0;
         neg_q  <= 1'b0;
`endif
      end else if (en) begin
         // NOTE: non-blocking assignments let each stage read its predecessor's old value.
         ctrl_q[0] <= '{valid: in_valid, carry: sl_cout[0], sub: in_sub};
         sum_q[0]  <= sum_d[0];
         a_q[0]    <= in_a;
         b_q[0]    <= in_b;
         for (int k = 1; k < STAGES; k++) begin
            ctrl_q[k] <= '{valid: ctrl_q[k-1].valid, carry: sl_cout[k],
                           sub: ctrl_q[k-1].sub};
            sum_q[k]  <= sum_d[k];
            a_q[k]    <= a_q[k-1];
            b_q[k]    <= b_q[k-1];
         end
         ovf_q <= sl_cmsb[STAGES-1] ^ sl_cout[STAGES-1];
`ifdef CLA_PIPE_FLAGS_EN
         zero_q <= (sum_d[STAGES-1] == '0);
         neg_q  <= sum_d[STAGES-1][WIDTH-1];
`endif
      end
   end

   assign out_valid = ctrl_q[STAGES-1].valid;
   assign out_sum   = sum_q[STAGES-1];
   assign out_cout  = ctrl_q[STAGES-1].carry;
   assign out_ovf   = ovf_q;

`ifdef CLA_PIPE_FLAGS_EN
   assign out_zero = zero_q;
   assign out_neg  = neg_q;
`endif

   // Operands past the last slice, group G/P and inner MSB carries are
   // structurally present but not needed downstream.
   logic unused_bits;
   assign unused_bits = ^{a_q[STAGES-1], b_q[STAGES-1], ctrl_q[STAGES-1].sub,
                          sl_g, sl_p, sl_cmsb};

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Self-checking bench for cla_pipe_adder (WIDTH=32, GROUP=8, latency 4).
// Expected results come from plain integer arithmetic on the operands.
module tb_cla_pipe_adder;

   localparam int WIDTH = 32;
   localparam int GROUP = 8;
   localparam int LAT   = WIDTH / GROUP;
   localparam longint SMAX = 64'sd2147483647;
   localparam longint SMIN = -64'sd2147483648;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic             in_sub = 1'b0;
   logic             in_cin = 1'b0;
   logic [WIDTH-1:0] in_a = '0;
   logic [WIDTH-1:0] in_b = '0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [WIDTH-1:0] out_sum;
   logic             out_cout;
   logic             out_ovf;
`ifdef CLA_PIPE_FLAGS_EN
   logic             out_zero;
   logic             out_neg;
`endif

   always #5 clk = ~clk;

   cla_pipe_adder #(.WIDTH(WIDTH), .GROUP(GROUP)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_sub    (in_sub),
      .in_cin    (in_cin),
      .in_a      (in_a),
      .in_b      (in_b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_cout  (out_cout),
      .out_ovf   (out_ovf)
`ifdef CLA_PIPE_FLAGS_EN
      ,
      .out_zero  (out_zero),
      .out_neg   (out_neg)
`endif
   );

   typedef struct {
      logic [WIDTH-1:0] sum;
      logic             cout;
      logic             ovf;
      logic             zero;
      logic             neg;
   } res_t;

   res_t exp_q[$];
   int   total = 0;
   int   bad   = 0;

   // Reference: unsigned sum for carry, signed sum range for overflow.
   function automatic res_t model(input logic sub, input logic cin,
                                  input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      res_t   m;
      longint ua, ub, sa, sb, r, t;
      ua = longint'(a);
      ub = longint'(b);
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      if (sub) begin
         m.sum  = a - b;
         m.cout = (a >= b);
         r      = sa - sb;
      end else begin
         t      = ua + ub + longint'(cin);
         m.sum  = t[WIDTH-1:0];
         m.cout = t[WIDTH];
         r      = sa + sb + longint'(cin);
      end
      m.ovf  = (r > SMAX) || (r < SMIN);
      m.zero = (m.sum == '0);
      m.neg  = m.sum[WIDTH-1];
      return m;
   endfunction

   function automatic logic [WIDTH-1:0] pick();
      case ($urandom_range(0, 7))
         0:       return 32'h0000_0000;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return 32'h7FFF_FFFF;
         4:       return 32'h0000_0001;
         default: return $urandom;
      endcase
   endfunction

   // Drive one cycle of inputs at negedge; report the handshakes the next
   // posedge will perform and record accepted beats in the model queue.
   task automatic cycle(input logic v, input logic sub, input logic cin,
                        input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic rdy, output logic acc, output logic del);
      @(negedge clk);
      in_valid  = v;
      in_sub    = sub;
      in_cin    = cin;
      in_a      = a;
      in_b      = b;
      out_ready = rdy;
      #1;
      acc = in_valid && in_ready;
      del = out_valid && out_ready;
      if (acc) exp_q.push_back(model(sub, cin, a, b));
   endtask

   task automatic test_reset();
      logic acc, del, seen;
      rst_n     = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         in_valid = 1'b1;
         in_a     = $urandom;
         in_b     = $urandom;
         #1;
         total++;
         if (out_valid !== 1'b0 || out_sum !== '0 || out_cout !== 1'b0 || out_ovf !== 1'b0)
            begin
               bad++;
               $display("FAIL reset_hold: valid=%b sum=%h cout=%b ovf=%b, want all 0",
                        out_valid, out_sum, out_cout, out_ovf);
            end
      end
      @(negedge clk);
      in_valid = 1'b0;
      rst_n    = 1'b1;
      #1;
      total++;
      if (in_ready !== 1'b1) begin
         bad++;
         $display("FAIL reset_in_ready: got %b want 1", in_ready);
      end
      seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
         cycle(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, acc, del);
         if (out_valid) seen = 1'b1;
      end
      total++;
      if (seen !== 1'b0) begin
         bad++;
         $display("FAIL reset_no_output: out_valid seen=%b want 0", seen);
      end
      exp_q.delete();
   endtask

   task automatic test_single(input string name, input logic sub, input logic cin,
                              input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                              input logic [WIDTH-1:0] e_sum, input logic e_cout,
                              input logic e_ovf);
      logic             acc, del;
      int               lat;
      logic [WIDTH-1:0] g_sum;
      logic             g_cout, g_ovf, g_zero, g_neg;
      cycle(1'b1, sub, cin, a, b, 1'b1, acc, del);
      total++;
      if (acc !== 1'b1) begin
         bad++;
         $display("FAIL %s_accept: got %b want 1", name, acc);
      end
      lat = 0;
      g_sum = '0; g_cout = 1'b0; g_ovf = 1'b0; g_zero = 1'b0; g_neg = 1'b0;
      for (int n = 1; n <= 12; n++) begin
         cycle(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, acc, del);
         if (del) begin
            lat    = n;
            g_sum  = out_sum;
            g_cout = out_cout;
            g_ovf  = out_ovf;
`ifdef CLA_PIPE_FLAGS_EN
            g_zero = out_zero;
            g_neg  = out_neg;
`endif
            break;
         end
      end
      total++;
      if (lat !== LAT) begin
         bad++;
         $display("FAIL %s_latency: got %0d want %0d", name, lat, LAT);
      end
      total++;
      if (g_sum !== e_sum || g_cout !== e_cout || g_ovf !== e_ovf) begin
         bad++;
         $display("FAIL %s_result: got sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b",
                  name, g_sum, g_cout, g_ovf, e_sum, e_cout, e_ovf);
      end
`ifdef CLA_PIPE_FLAGS_EN
      total++;
      if (g_zero !== (e_sum == '0) || g_neg !== e_sum[WIDTH-1]) begin
         bad++;
         $display("FAIL %s_flags: got zero=%b neg=%b want zero=%b neg=%b",
                  name, g_zero, g_neg, (e_sum == '0), e_sum[WIDTH-1]);
      end
`endif
      exp_q.delete();
   endtask

   task automatic test_back_to_back();
      logic             acc, del, rdy, seen;
      logic [WIDTH-1:0] ta[6], tb[6];
      logic             ts[6], tc[6];
      logic [WIDTH+1:0] held;
      int               sent, got, stall, idx;
      res_t             e;
      for (int i = 0; i < 6; i++) begin
         ta[i] = pick(); tb[i] = pick();
         ts[i] = $urandom_range(0, 1); tc[i] = $urandom_range(0, 1);
      end
      sent = 0; got = 0; stall = 0; seen = 1'b0; held = '0;
      for (int i = 0; i < 60 && got < 6; i++) begin
         rdy = (stall == 0);
         idx = (sent < 6) ? sent : 5;
         cycle(sent < 6, ts[idx], tc[idx], ta[idx], tb[idx], rdy, acc, del);
         if (acc) sent++;
         if (stall > 0) begin
            total++;
            if (in_ready !== 1'b0) begin
               bad++;
               $display("FAIL bp_in_ready: got %b want 0 during stall", in_ready);
            end
            if (stall == 3) held = {out_sum, out_cout, out_ovf};
            else begin
               total++;
               if ({out_sum, out_cout, out_ovf} !== held || out_valid !== 1'b1) begin
                  bad++;
                  $display("FAIL bp_hold: got %h valid=%b want %h valid=1",
                           {out_sum, out_cout, out_ovf}, out_valid, held);
               end
            end
            stall--;
         end
         if (del) begin
            total++;
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL bp_extra: got sum=%h with no beat pending", out_sum);
            end else begin
               e = exp_q.pop_front();
               if (out_sum !== e.sum || out_cout !== e.cout || out_ovf !== e.ovf) begin
                  bad++;
                  $display("FAIL bp_result: got sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b",
                           out_sum, out_cout, out_ovf, e.sum, e.cout, e.ovf);
               end
            end
            got++;
         end
         if (out_valid && !seen) begin
            seen  = 1'b1;
            stall = 3;
         end
      end
      total++;
      if (got !== 6 || sent !== 6 || exp_q.size() !== 0) begin
         bad++;
         $display("FAIL bp_count: got delivered=%0d sent=%0d pending=%0d want 6/6/0",
                  got, sent, exp_q.size());
      end
      exp_q.delete();
   endtask

   task automatic test_random();
      logic acc, del, v, rdy;
      res_t e;
      int   n_out;
      n_out = 0;
      for (int i = 0; i < 400; i++) begin
         if (i >= 300 && exp_q.size() == 0) break;
         v   = (i < 300) && ($urandom_range(0, 9) < 7);
         rdy = ($urandom_range(0, 3) != 0);
         cycle(v, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), pick(), pick(),
               rdy, acc, del);
         if (del) begin
            total++;
            n_out++;
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL rand_extra: got sum=%h with no beat pending", out_sum);
            end else begin
               e = exp_q.pop_front();
               if (out_sum !== e.sum || out_cout !== e.cout || out_ovf !== e.ovf
`ifdef CLA_PIPE_FLAGS_EN
                   || out_zero !== e.zero || out_neg !== e.neg
`endif
                  ) begin
                  bad++;
                  $display("FAIL rand_result: got sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b",
                           out_sum, out_cout, out_ovf, e.sum, e.cout, e.ovf);
               end
            end
         end
      end
      total++;
      if (exp_q.size() != 0 || n_out == 0) begin
         bad++;
         $display("FAIL rand_drain: got pending=%0d delivered=%0d want 0 and >0",
                  exp_q.size(), n_out);
      end
      exp_q.delete();
   endtask

   task automatic test_reset_midflight();
      logic acc, del, seen;
      for (int i = 0; i < 3; i++)
         cycle(1'b1, 1'b0, 1'b0, $urandom, $urandom, 1'b0, acc, del);
      for (int i = 0; i < 2; i++)
         cycle(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, acc, del);
      total++;
      if (out_valid !== 1'b1) begin
         bad++;
         $display("FAIL midrst_pre: got out_valid=%b want 1", out_valid);
      end
      #2;
      rst_n = 1'b0;
      #1;
      total++;
      if (out_valid !== 1'b0 || out_sum !== '0 || out_cout !== 1'b0 || out_ovf !== 1'b0) begin
         bad++;
         $display("FAIL midrst_async: valid=%b sum=%h cout=%b ovf=%b want all 0",
                  out_valid, out_sum, out_cout, out_ovf);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      exp_q.delete();
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         cycle(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, acc, del);
         if (out_valid) seen = 1'b1;
      end
      total++;
      if (seen !== 1'b0) begin
         bad++;
         $display("FAIL midrst_stale: out_valid seen=%b want 0", seen);
      end
   endtask

   initial begin
      test_reset();
      test_single("add_ff_1",   1'b0, 1'b0, 32'h0000_00FF, 32'h0000_0001,
                  32'h0000_0100, 1'b0, 1'b0);
      test_single("add_wrap",   1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001,
                  32'h0000_0000, 1'b1, 1'b0);
      test_single("sub_ovf",    1'b1, 1'b0, 32'h8000_0000, 32'h0000_0001,
                  32'h7FFF_FFFF, 1'b1, 1'b1);
      test_single("sub_borrow", 1'b1, 1'b1, 32'h0000_0000, 32'h0000_0001,
                  32'hFFFF_FFFF, 1'b0, 1'b0);
      test_back_to_back();
      test_random();
      test_reset_midflight();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
